serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial add/subtract controller that time-shares a single 1-bit full-adder cell across a WIDTH-bit operation, one bit per clock, LSB first. It accepts operands over a valid/ready input handshake and sequences the operand and sum shift registers and the carry flip-flop through the cell. It returns sum, carry and signed overflow over a valid/ready output handshake. It sits between a requester (register file / test sequencer) and the shared adder cell, where area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  requester presents a, b, sub
in_ready  output  1  controller can accept an operation
a  input  WIDTH  operand A (captured on input handshake)
b  input  WIDTH  operand B (captured on input handshake)
sub  input  1  0: A+B, 1: A-B (captured on input handshake)
out_valid  output  1  result fields valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
carry_out  output  1  final carry; for subtract, 1 = no borrow
overflow  output  1  signed (two's-complement) overflow

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; sum=0, carry_out=0, overflow=0, out_valid=0, in_ready=1; operand registers, bit counter and carry FF cleared. Reset mid-RUN or mid-DONE aborts the operation; no result is produced.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE: on in_valid & in_ready at edge k, the controller:
  - captures A into shift reg SA;
  - captures (sub ? ~b : b) into SB;
  - sets the carry FF to sub;
  - clears the counter;
  - moves to RUN.
  in_valid without in_ready is ignored; the requester must hold its inputs.
- RUN: each cycle drives SA[0], SB[0] and the carry FF into the full-adder cell.
  - Cell sum bit shifts into the MSB of the sum register (right shift).
  - Cell carry loads the carry FF.
  - SA and SB shift right.
  - Counter increments.
  - On the cycle with counter==WIDTH-1: latch overflow = (carry into MSB) XOR (carry out of MSB), i.e. the carry FF value before the edge XOR the cell carry; latch carry_out = cell carry; go to DONE.
- Latency: out_valid rises WIDTH cycles after the accepting edge (edge k+WIDTH). Exactly WIDTH cell evaluations per operation.
- DONE: sum, carry_out and overflow are held stable while out_valid=1 and out_ready=0, for any number of cycles. On out_valid & out_ready, go to IDLE; in_ready=1 from the next cycle. Result registers keep their last value in IDLE. No new operation is accepted in DONE.
- The result equals (A + B) mod 2^WIDTH or (A - B) mod 2^WIDTH. carry_out is the unsigned carry / not-borrow.
- Sampling in_valid or out_ready as X in IDLE/DONE is a bench error; the RTL need not handle it.

Test Plan:
- WIDTH=8, A=0x5A, B=0x3C, sub=0 -> after 8 cycles sum=0x96, carry_out=0, overflow=1; out_valid rises exactly 8 cycles after the accepting edge.
- A=0xFF, B=0x01, sub=0 -> sum=0x00, carry_out=1, overflow=0. A=0x7F, B=0x01 -> sum=0x80, carry_out=0, overflow=1.
- sub=1, A=0x10, B=0x20 -> sum=0xF0, carry_out=0, overflow=0. A=0x80, B=0x01 -> sum=0x7F, carry_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, carry_out and overflow stable. in_valid=1 with new operands during DONE is not accepted (in_ready=0). After out_ready=1, the next operation is accepted in IDLE and computes correctly.
- Reset: assert rst_n=0 at bit 4 of RUN -> outputs immediately 0, in_ready=1, out_valid=0. After release, a fresh A=0x01, B=0x01 gives sum=0x02 with no stale carry.
- Back-to-back random regression: 1000 random (A, B, sub) with random in_valid/out_ready gaps -> every result matches the reference model; operation count in = out.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: shares one full-adder cell across a
// WIDTH-bit operation, LSB first, with valid/ready handshakes on both sides.
module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             cell_sum;
  logic             cell_carry;
  logic             last_bit;

  // Shared 1-bit full-adder cell fed from the operand LSBs and the carry FF.
  always_comb begin
    cell_sum   = sa_q[0] ^ sb_q[0] ^ carry_q;
    cell_carry = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
    last_bit   = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Controller FSM with datapath shift registers and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Subtraction is A + ~B + 1: invert B and preload the carry with 1.
          if (in_valid) begin
            sa_q       <= a;
            sb_q       <= sub ? ~b : b;
            carry_q    <= sub;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          sa_q    <= {1'b0, sa_q[WIDTH-1:1]};
          sb_q    <= {1'b0, sb_q[WIDTH-1:1]};
          acc_q   <= {cell_sum, acc_q[WIDTH-1:1]};
          carry_q <= cell_carry;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            // carry_q here is the carry into the MSB; cell_carry is the carry out.
            sum_q       <= {cell_sum, acc_q[WIDTH-1:1]};
            cout_q      <= cell_carry;
            ovf_q       <= carry_q ^ cell_carry;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases, backpressure,
// mid-operation reset and a randomized regression against an arithmetic model.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       carry_out;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                                output logic [7:0] r, output logic c, output logic v);
    int ua, ub, sa, sb, full, sres;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (!sv) begin
      full = ua + ub;
      c    = (full > 255);
      sres = sa + sb;
    end else begin
      full = ua - ub;
      c    = (ua >= ub);
      sres = sa - sb;
    end
    r = 8'(full & 255);
    v = (sres > 127) || (sres < -128);
  endfunction

  // Present an operation and return at the negedge after the accepting edge.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    int guard = 0;
    @(negedge clk);
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_accept: in_ready=%0b required 1 within 100 cycles", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
  endtask

  // Run one operation: returns latency in cycles and the observed result fields.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic sv, input int hold,
                        output int lat, output logic [7:0] r, output logic c, output logic v);
    send(av, bv, sv);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    r = sum; c = carry_out; v = overflow;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, sum, carry_out, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got rdy=%0b vld=%0b sum=%h c=%0b v=%0b required 1 0 00 0 0",
               in_ready, out_valid, sum, carry_out, overflow);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] da [5] = '{8'h5A, 8'hFF, 8'h7F, 8'h10, 8'h80};
    logic [7:0] db [5] = '{8'h3C, 8'h01, 8'h01, 8'h20, 8'h01};
    logic       ds [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] es [5] = '{8'h96, 8'h00, 8'h80, 8'hF0, 8'h7F};
    logic       ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       ev [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int lat;
    logic [7:0] r;
    logic c, v;
    for (int i = 0; i < 5; i++) begin
      run_op(da[i], db[i], ds[i], 0, lat, r, c, v);
      total++;
      if (lat !== 8) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d required 8", i, lat);
      end
      total++;
      if ({r, c, v} !== {es[i], ec[i], ev[i]}) begin
        bad++;
        $display("FAIL directed_result[%0d]: got sum=%h c=%0b v=%0b required sum=%h c=%0b v=%0b",
                 i, r, c, v, es[i], ec[i], ev[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] r0, er;
    logic c0, v0, ec, ev;
    int lat;
    send(8'h33, 8'h44, 1'b0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    r0 = sum; c0 = carry_out; v0 = overflow;
    model(8'h33, 8'h44, 1'b0, er, ec, ev);
    total++;
    if ({r0, c0, v0} !== {er, ec, ev}) begin
      bad++;
      $display("FAIL bp_result: got sum=%h c=%0b v=%0b required sum=%h c=%0b v=%0b", r0, c0, v0, er, ec, ev);
    end
    a = 8'h12; b = 8'h34; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, sum, carry_out, overflow} !== {1'b1, 1'b0, r0, c0, v0}) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got vld=%0b rdy=%0b sum=%h c=%0b v=%0b required 1 0 %h %0b %0b",
                 i, out_valid, in_ready, sum, carry_out, overflow, r0, c0, v0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_release: got rdy=%0b vld=%0b required 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    model(8'h12, 8'h34, 1'b1, er, ec, ev);
    total++;
    if ({lat, sum, carry_out, overflow} !== {32'd8, er, ec, ev}) begin
      bad++;
      $display("FAIL bp_next_op: got lat=%0d sum=%h c=%0b v=%0b required 8 %h %0b %0b",
               lat, sum, carry_out, overflow, er, ec, ev);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_midrun_reset();
    int lat, seen;
    logic [7:0] r;
    logic c, v;
    send(8'hA5, 8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, sum, carry_out, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midrun_reset: got rdy=%0b vld=%0b sum=%h c=%0b v=%0b required 1 0 00 0 0",
               in_ready, out_valid, sum, carry_out, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL midrun_no_result: got %0d valid cycles required 0", seen);
    end
    run_op(8'h01, 8'h01, 1'b0, 1, lat, r, c, v);
    total++;
    if ({lat, r, c, v} !== {32'd8, 8'h02, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL post_reset_op: got lat=%0d sum=%h c=%0b v=%0b required 8 02 0 0", lat, r, c, v);
    end
  endtask

  task automatic test_back_to_back();
    int n_in = 0, n_out = 0, lat;
    logic [7:0] av, bv, r, er;
    logic sv, c, v, ec, ev;
    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom); bv = 8'($urandom); sv = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      model(av, bv, sv, er, ec, ev);
      n_in++;
      run_op(av, bv, sv, $urandom_range(0, 3), lat, r, c, v);
      if (lat < 50) n_out++;
      total++;
      if ({lat, r, c, v} !== {32'd8, er, ec, ev}) begin
        bad++;
        $display("FAIL random[%0d] a=%h b=%h sub=%0b: got lat=%0d sum=%h c=%0b v=%0b required 8 %h %0b %0b",
                 i, av, bv, sv, lat, r, c, v, er, ec, ev);
      end
    end
    total++;
    if (n_out !== n_in) begin
      bad++;
      $display("FAIL random_count: got %0d results required %0d", n_out, n_in);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_midrun_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
